// File: rtl/icache_refill_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_bridge_if
// Brief    : ICache refill request/response plus word-wide read channel.
// Revision : 1.0 - initial release
// ============================================================================
interface icache_refill_bridge_if #(
  parameter int WORD       = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  memory_valid;
  logic [WORD-1:0]       load_addr;
  logic                  memory_ready;
  logic [LINE_WIDTH-1:0] inst_from_mem;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [WORD-1:0]       ar_addr;
  logic [7:0]            ar_len;
  logic                  r_valid;
  logic [WORD-1:0]       r_data;
  logic                  r_last;
  logic                  r_ready;
  logic                  busy;
  logic                  protocol_err;

  // Bridge side
  modport slave (
    input  memory_valid, load_addr, ar_ready, r_valid, r_data, r_last,
    output memory_ready, inst_from_mem, ar_valid, ar_addr, ar_len, r_ready,
           busy, protocol_err
  );

  // ICache + memory side
  modport master (
    output memory_valid, load_addr, ar_ready, r_valid, r_data, r_last,
    input  memory_ready, inst_from_mem, ar_valid, ar_addr, ar_len, r_ready,
           busy, protocol_err
  );
endinterface
`default_nettype wire

// File: rtl/icache_refill_bridge.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_bridge
// Brief    : Refills one ICache line with a single incrementing read burst.
// Revision : 1.0 - initial release
// ============================================================================
module icache_refill_bridge #(
  parameter int WORD       = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  icache_refill_bridge_if.slave bus
);
  localparam int BEATS      = LINE_WIDTH / WORD;
  localparam int OFFSET_LOG = $clog2(LINE_WIDTH / 8);
  localparam int c_cnt_w    = $clog2(BEATS);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [WORD-1:0]       r_ar_addr;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_mem_ready;
  logic                  r_err;

  logic w_beat;
  logic w_last_beat;
  logic w_line_match;

  assign w_beat       = (r_state == DATA) && bus.r_valid;
  assign w_last_beat  = (r_cnt == c_last_beat);
  assign w_line_match = (bus.load_addr[WORD-1:OFFSET_LOG] == r_ar_addr[WORD-1:OFFSET_LOG]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.memory_valid) w_state_nxt = ADDR;
      ADDR:    if (bus.ar_ready) w_state_nxt = DATA;
      DATA:    if (w_beat && w_last_beat) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_ar_addr   <= '0;
      r_line      <= '0;
      r_mem_ready <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Decide the hand-back on the final beat so the DONE-cycle pulse is registered.
      r_mem_ready <= w_beat && w_last_beat && bus.memory_valid && w_line_match;

      if ((r_state == IDLE) && bus.memory_valid) begin
        r_ar_addr <= {bus.load_addr[WORD-1:OFFSET_LOG], {OFFSET_LOG{1'b0}}};
        r_cnt     <= '0;
      end

      if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
        for (int k = 0; k < BEATS; k++) begin
          if (r_cnt == c_cnt_w'(k)) begin
            r_line[k*WORD +: WORD] <= bus.r_data;
          end
        end
        // Burst length follows the counter; r_last is only cross-checked.
        if (bus.r_last != w_last_beat) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.memory_ready  = r_mem_ready;
  assign bus.inst_from_mem = r_line;
  assign bus.ar_valid      = (r_state == ADDR);
  assign bus.ar_addr       = r_ar_addr;
  assign bus.ar_len        = 8'(BEATS - 1);
  assign bus.r_ready       = (r_state == DATA);
  assign bus.busy          = (r_state != IDLE);
  assign bus.protocol_err  = r_err;

endmodule
`default_nettype wire

// File: doc/icache_refill_bridge.md
# icache_refill_bridge

Memory-side refill engine for the instruction cache. It accepts a line-miss request (`memory_valid`/`load_addr`) from the ICache FSM, issues one incrementing read burst on a word-wide AXI-style read channel, assembles the returned beats into a full cache line, and hands the line back via `memory_ready`/`inst_from_mem`. It sits directly downstream of the ICache, between it and the instruction memory/bus.

## Interface
Parameters:
- `WORD`, 32, bus/data word width in bits
- `LINE_WIDTH`, 128, cache line width in bits; must be a multiple of `WORD`
- `BEATS`, `LINE_WIDTH/WORD` (derived), beats per refill burst; power of two, ≥2
- `OFFSET_LOG`, log2(`LINE_WIDTH/8`) (derived), byte-offset bits inside a line

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `memory_valid`  in  1  ICache refill request, held high until `memory_ready`
- `load_addr`  in  `WORD`  miss address (any byte inside the line)
- `memory_ready`  out  1  one-cycle pulse: `inst_from_mem` holds the requested line
- `inst_from_mem`  out  `LINE_WIDTH`  assembled line, registered
- `ar_valid`  out  1  read-address valid
- `ar_ready`  in  1  read-address accepted
- `ar_addr`  out  `WORD`  line-aligned burst address
- `ar_len`  out  8  constant `BEATS-1`
- `r_valid`  in  1  read-data beat valid
- `r_data`  in  `WORD`  read-data beat
- `r_last`  in  1  final-beat marker from memory
- `r_ready`  out  1  bridge accepts a beat
- `busy`  out  1  high in any state except IDLE
- `protocol_err`  out  1  sticky: `r_last` disagreed with beat count

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: if `memory_valid`, latch `{load_addr[WORD-1:OFFSET_LOG], OFFSET_LOG'b0}` into `ar_addr`, clear beat counter, go ADDR.
- ADDR: `ar_valid`=1, `ar_addr` stable; on `ar_ready` go DATA. `ar_valid` never drops before `ar_ready`.
- DATA: `r_ready`=1. Each `r_valid` beat k (k = 0..BEATS-1) writes `r_data` into line bits `[k*WORD +: WORD]` (beat 0 = lowest word); counter increments. Beat with k = `BEATS-1` → DONE.
- `r_last` check: `r_last`=1 on k < `BEATS-1`, or `r_last`=0 on k = `BEATS-1`, sets `protocol_err`. The burst length is governed by the counter only; `r_last` never ends a burst early.
- DONE (one cycle): if `memory_valid`=1 and `load_addr[WORD-1:OFFSET_LOG]` equals latched line address → `memory_ready`=1. Otherwise (request withdrawn by flush, or replaced by a different line) → `memory_ready`=0, line discarded. Always → IDLE.
- Address accepted → burst always runs to completion; the memory channel has no abort.
- Contract with the ICache: `memory_valid` falls in the cycle after `memory_ready`; IDLE therefore never re-issues a serviced line.
- Counter width: log2(`BEATS`) bits; wraps to 0 on the last beat.

## Timing
- Reset values: state IDLE, `memory_ready` 0, `inst_from_mem` 0, `ar_valid` 0, `ar_addr` 0, `r_ready` 0, `busy` 0, `protocol_err` 0. `ar_len` is constant.
- All outputs are registered or decoded from state only; nothing is combinational from inputs.
- Minimum latency: `memory_valid` sampled at edge t → `ar_valid` high in cycle t+1; with `ar_ready`=1 and back-to-back beats, DATA covers t+2..t+1+BEATS, and `memory_ready` is high in cycle t+2+BEATS (6 cycles for BEATS=4).
- `r_valid` gaps stall the counter; the line is not updated on cycles with `r_valid`=0.
- `inst_from_mem` holds its value from DONE until the first beat of the next burst.
- Back-to-back: earliest new request is sampled in the cycle after DONE.
- Asynchronous `rst` at any point → IDLE immediately, partial line discarded, all outputs return to reset values. `protocol_err` clears only on `rst`.

## Test plan
- Basic refill, BEATS=4: `load_addr`=0x1C00_0034, `ar_ready`=1, beats 0x11,0x22,0x33,0x44 back-to-back with `r_last` on beat 3 → `ar_addr`=0x1C00_0030, `ar_len`=3, `memory_ready` exactly 6 cycles after request, `inst_from_mem`=0x00000044_00000033_00000022_00000011.
- Backpressure: `ar_ready` held low 3 cycles and `r_valid` gaps of 2 cycles between beats → `ar_valid`/`ar_addr` stable throughout, same line assembled, `memory_ready` single-cycle pulse.
- Flush mid-burst: drop `memory_valid` after beat 1 → burst completes (4 beats consumed), no `memory_ready`, `busy` low after DONE.
- Redirect mid-burst: drop `memory_valid`, then raise it with 0x1C00_0100 during DATA → first line discarded; second burst issued with `ar_addr`=0x1C00_0100, which gets `memory_ready`.
- Protocol error: `r_last`=1 on beat 1 → `protocol_err`=1 and stays 1; 4 beats are still collected and `memory_ready` still pulses.
- Async reset during DATA after beat 2 → `busy`, `r_ready`, `memory_ready` fall to 0 without a clock edge; the next request starts a fresh burst from beat 0.
